// File: rtl/prog_seq_counter.sv
// rtl/prog_seq_counter.sv - run-time programmable sequence counter over a loadable code table
//
// Steps an index through table[0..L-1] forward or backward and presents
// table[idx] on out. L comes from len (0 or > DEPTH means DEPTH).
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (idx=0, wrap=0, table=identity)
//   clr      synchronous restart to idx=0, wins over en, table untouched
//   en       advance one position per cycle while high
//   dir      0 = forward, 1 = backward
//   len      active sequence length (AW+1 bits)
//   wr_en    table write strobe, independent of stepping
//   wr_addr  table write address (addresses >= DEPTH are dropped)
//   wr_data  table write data
//   out      table[idx] on the current registers
//   idx      current table position
//   wrap     registered one-cycle pulse when the last step wrapped

module prog_seq_counter #(
   parameter int W     = 4,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic          dir,
   input  logic [AW:0]   len,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   output logic [W-1:0]  out,
   output logic [AW-1:0] idx,
   output logic          wrap
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [W-1:0]  tbl [DEPTH];
   logic [AW:0]   len_eff;
   logic [AW:0]   last;
   logic [AW:0]   idx_ext;
   logic [AW-1:0] idx_nxt;
   logic          wrap_nxt;

   always_comb begin
      len_eff = ((len == '0) || (len > DEPTH_L)) ? DEPTH_L : len;
      last    = len_eff - (AW+1)'(1);
      idx_ext = {1'b0, idx};
   end

   always_comb begin
      idx_nxt  = idx;
      wrap_nxt = 1'b0;
      if (clr) begin
         idx_nxt  = '0;
         wrap_nxt = 1'b0;
      end else if (en) begin
         // idx can sit beyond the active length after len shrinks mid-run;
         // both directions restart at 0 and flag a wrap in that case.
         if (idx_ext >= len_eff) begin
            idx_nxt  = '0;
            wrap_nxt = 1'b1;
         end else if (!dir) begin
            if (idx_ext == last) begin
               idx_nxt  = '0;
               wrap_nxt = 1'b1;
            end else begin
               idx_nxt = idx + AW'(1);
            end
         end else begin
            if (idx == '0) begin
               idx_nxt  = last[AW-1:0];
               wrap_nxt = 1'b1;
            end else begin
               idx_nxt = idx - AW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx  <= '0;
         wrap <= 1'b0;
      end else begin
         idx  <= idx_nxt;
         wrap <= wrap_nxt;
      end
   end

   // Table resets to the identity pattern so the block counts 0,1,2,...
   // out of reset without any programming.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl[i] <= W'(i);
         end
      end else if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
         tbl[wr_addr] <= wr_data;
      end
   end

   // Combinational read so a write to the entry idx lands on shows the same cycle.
   assign out = tbl[idx];

endmodule

// File: tb/tb_prog_seq_counter.sv
// tb/tb_prog_seq_counter.sv - directed self-checking bench for prog_seq_counter
module tb_prog_seq_counter;

   localparam int W = 4;
   localparam int DEPTH = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic          en = 1'b0;
   logic          dir = 1'b0;
   logic [AW:0]   len = '0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic [W-1:0]  out;
   logic [AW-1:0] idx;
   logic          wrap;

   int checks = 0;
   int errors = 0;

   prog_seq_counter #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .dir(dir), .len(len),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .out(out), .idx(idx), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b0; en = 1'b0; dir = 1'b0; wr_en = 1'b0; len = '0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (idx !== 3'd0 || out !== 4'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_async got idx=%0d out=%0d wrap=%0b want 0 0 0", idx, out, wrap);
      end
      en = 1'b1;
      tick();
      checks++;
      if (idx !== 3'd0 || out !== 4'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_held got idx=%0d out=%0d wrap=%0b want 0 0 0", idx, out, wrap);
      end
      do_reset();
   endtask

   task automatic test_five();
      logic [W-1:0] exp_out [7] = '{4'd2, 4'd5, 4'd3, 4'd4, 4'd0, 4'd2, 4'd5};
      logic         exp_wr  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [W-1:0] exp_bo  [6] = '{4'd4, 4'd3, 4'd5, 4'd2, 4'd0, 4'd4};
      logic         exp_bw  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      wr(3'd0, 4'd0); wr(3'd1, 4'd2); wr(3'd2, 4'd5); wr(3'd3, 4'd3); wr(3'd4, 4'd4);
      checks++;
      if (out !== 4'd0 || idx !== 3'd0) begin
         errors++;
         $display("FAIL five_start got idx=%0d out=%0d want 0 0", idx, out);
      end
      len = 4'd5; dir = 1'b0; en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (out !== exp_out[i] || wrap !== exp_wr[i]) begin
            errors++;
            $display("FAIL five_fwd[%0d] got out=%0d wrap=%0b want %0d %0b", i, out, wrap, exp_out[i], exp_wr[i]);
         end
      end
      en = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (idx !== 3'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL five_clr got idx=%0d wrap=%0b want 0 0", idx, wrap);
      end
      dir = 1'b1; en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (out !== exp_bo[i] || wrap !== exp_bw[i]) begin
            errors++;
            $display("FAIL five_bwd[%0d] got out=%0d wrap=%0b want %0d %0b", i, out, wrap, exp_bo[i], exp_bw[i]);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_shrink();
      logic [AW-1:0] exp_i [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
      logic          exp_w [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      len = 4'd8; en = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (idx !== 3'd6) begin
         errors++;
         $display("FAIL shrink_pre got idx=%0d want 6", idx);
      end
      len = 4'd3;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (idx !== exp_i[i] || wrap !== exp_w[i] || out !== {1'b0, exp_i[i]}) begin
            errors++;
            $display("FAIL shrink[%0d] got idx=%0d out=%0d wrap=%0b want %0d %0d %0b", i, idx, out, wrap, exp_i[i], exp_i[i], exp_w[i]);
         end
      end
      do_reset();
      len = 4'd8; en = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      len = 4'd3; dir = 1'b1;
      tick();
      checks++;
      if (idx !== 3'd0 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL shrink_bwd_out got idx=%0d wrap=%0b want 0 1", idx, wrap);
      end
      tick();
      checks++;
      if (idx !== 3'd2 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL shrink_bwd_wrap got idx=%0d wrap=%0b want 2 1", idx, wrap);
      end
      tick();
      checks++;
      if (idx !== 3'd1 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL shrink_bwd_step got idx=%0d wrap=%0b want 1 0", idx, wrap);
      end
      en = 1'b0; dir = 1'b0;
   endtask

   task automatic test_len0();
      logic [AW-1:0] exp_i [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      logic          exp_w [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      len = 4'd0; en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (idx !== exp_i[i] || wrap !== exp_w[i] || out !== {1'b0, exp_i[i]}) begin
            errors++;
            $display("FAIL len0[%0d] got idx=%0d out=%0d wrap=%0b want %0d %0d %0b", i, idx, out, wrap, exp_i[i], exp_i[i], exp_w[i]);
         end
      end
      en = 1'b0;
      tick();
      checks++;
      if (idx !== 3'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL len0_hold got idx=%0d wrap=%0b want 0 0", idx, wrap);
      end
   endtask

   task automatic test_priority();
      do_reset();
      len = 4'd0; en = 1'b1;
      tick(); tick(); tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (idx !== 3'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL clr_over_en got idx=%0d wrap=%0b want 0 0", idx, wrap);
      end
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'hA;
      tick();
      checks++;
      if (idx !== 3'd1 || out !== 4'hA) begin
         errors++;
         $display("FAIL write_step got idx=%0d out=%0h want 1 a", idx, out);
      end
      en = 1'b0; wr_data = 4'hC;
      tick();
      wr_en = 1'b0;
      checks++;
      if (idx !== 3'd1 || out !== 4'hC) begin
         errors++;
         $display("FAIL write_hold got idx=%0d out=%0h want 1 c", idx, out);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < DEPTH; i++) wr(AW'(i), W'(15 - i));
      len = 4'd0; en = 1'b1;
      tick(); tick(); tick(); tick();
      checks++;
      if (idx !== 3'd4 || out !== 4'd11) begin
         errors++;
         $display("FAIL custom_run got idx=%0d out=%0d want 4 11", idx, out);
      end
      #3;
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h9;
      rst = 1'b1;
      #1;
      checks++;
      if (idx !== 3'd0 || out !== 4'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL async_mid got idx=%0d out=%0d wrap=%0b want 0 0 0", idx, out, wrap);
      end
      tick();
      rst = 1'b0; wr_en = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (out !== W'(i) || idx !== AW'(i)) begin
            errors++;
            $display("FAIL async_identity[%0d] got idx=%0d out=%0d want %0d %0d", i, idx, out, i, i);
         end
      end
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_five();
      test_shrink();
      test_len0();
      test_priority();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
